mux4_rr_arbiter: RTL
====================

// Module: mux4_rr_arbiter
// PURPOSE
//   Shares one 4:1 output datapath among four requesters with round-robin fairness.
//   Each requester presents req[i] and a WIDTH-bit data word.
//   The block grants one owner, drives the mux select and steers that owner's data
//   to a single valid/ready output channel.
//   An owner is held for a burst of up to MAX_BURST transfers, then ownership rotates.
//   Sits in front of any shared sink, such as a bus or serializer, that the 4:1 mux feeds.
// PARAMETERS
//   WIDTH      8   data width of each input and of out_data
//   MAX_BURST  4   max transfers per grant before forced rotation; legal range 1..15
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   req        in   4      req[i]=1: requester i has data pending
//   d0..d3     in   WIDTH  data word of requester 0..3
//   out_ready  in   1      sink accepts out_data this cycle
//   out_valid  out  1      out_data valid (combinational)
//   out_data   out  WIDTH  data of granted requester (combinational)
//   gnt        out  4      one-hot grant, registered; 0 = no owner
//   sel        out  2      binary index of owner: 00 -> d0, 01 -> d1, 10 -> d2, 11 -> d3
//   ack        out  4      ack[i]=1: requester i's word transferred this cycle
// BEHAVIOUR
//   Reset (async, rst=1):
//     - state=IDLE, gnt=0, sel=00, ptr=0, bcnt=0.
//     - Therefore out_valid=0, out_data=0, ack=0.
//     - An in-flight transfer is dropped and not acked.
//   Datapath:
//     - out_data = d[sel] when gnt!=0, else 0.
//     - out_valid = (gnt!=0) & req[sel].
//     - ack[i] = gnt[i] & out_valid & out_ready.
//   Transfer: a cycle with out_valid & out_ready. Otherwise data is held and bcnt is unchanged.
//   Arbitration (arb):
//     - Scan req from index ptr upward, wrapping 3 -> 0.
//     - The first set bit wins.
//   FSM, two states:
//     - IDLE:
//       - If req!=0, register gnt/sel = arb winner, bcnt=0 -> GRANT.
//       - Else stay IDLE.
//       - Latency req -> gnt is 1 cycle.
//     - GRANT: release when either condition holds at the clock edge:
//       - req[sel]==0, or
//       - a transfer occurs with bcnt==MAX_BURST-1. This final transfer is acked.
//     - GRANT, no release: bcnt += transfer (4-bit counter, never exceeds MAX_BURST-1).
//     - On release:
//       - ptr <= sel+1 mod 4, so the old owner becomes lowest priority.
//       - Re-arbitrate in the same edge using the new ptr and the current req.
//       - Winner found: new gnt/sel next cycle, bcnt=0, stay GRANT. No idle bubble.
//       - Old owner is the only requester: it is re-granted with bcnt=0.
//       - req==0 after release: gnt=0 -> IDLE.
//   Boundary conditions:
//     - Owner drops req mid-burst: out_valid falls the same cycle, release at the next edge.
//     - out_ready low: grant held indefinitely, no timeout.
//     - Requests arriving during a burst wait until release; no preemption.
//     - MAX_BURST=1: rotate after every transfer.
//     - Reset deasserted while req is high: first grant goes to the lowest set index (ptr=0).
//   gnt is always one-hot or zero, and sel always equals the gnt index.
// TESTING
//   1. rst=1 with random req/d -> gnt=0000, sel=00, out_valid=0, ack=0 immediately (async).
//   2. req=0100, d2=8'hA5, out_ready=1 -> next cycle gnt=0100, sel=10, out_data=A5;
//      ack[2] high 4 cycles, then re-grant to 2 with no gap.
//   3. req=1111 held, out_ready=1 -> owners 0,1,2,3,0 with exactly 4 acks each;
//      gnt changes on the edge after each 4th ack.
//   4. Owner 1 granted, out_ready=0 for 3 cycles -> ack=0, gnt=0010 held;
//      bcnt resumes from its held value when out_ready returns.
//   5. Owner 1 after 2 transfers drops req, req[3]=1 -> out_valid=0 that cycle;
//      next cycle gnt=1000, sel=11.
//   6. rst pulsed mid-burst of owner 2 -> outputs cleared at once;
//      after release with req=0101, the grant goes to 0 (ptr reset).

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin burst arbiter steering one of four requesters onto a
//            shared valid/ready channel through a 4:1 data mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [3:0]       ack
);

  localparam logic [3:0] c_last = 4'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_n;
  logic [3:0] r_gnt, w_gnt_n;
  logic [1:0] r_sel, w_sel_n;
  logic [1:0] r_ptr, w_ptr_n;
  logic [3:0] r_bcnt, w_bcnt_n;

  logic       w_xfer;
  logic       w_rel;
  logic [1:0] w_scan_ptr;
  logic [1:0] w_win;

  // Scan from p upward with wrap; the smallest offset from p that is set wins.
  function automatic logic [1:0] f_arb(input logic [3:0] rq, input logic [1:0] p);
    logic [1:0] idx;
    f_arb = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (rq[idx]) f_arb = idx;
    end
  endfunction

  always_comb begin
    out_data = '0;
    if (r_gnt != 4'b0000) begin
      case (r_sel)
        2'd0:    out_data = d0;
        2'd1:    out_data = d1;
        2'd2:    out_data = d2;
        default: out_data = d3;
      endcase
    end
  end

  assign out_valid = (r_gnt != 4'b0000) & req[r_sel];
  assign w_xfer    = out_valid & out_ready;
  assign ack       = r_gnt & {4{w_xfer}};
  assign gnt       = r_gnt;
  assign sel       = r_sel;

  assign w_rel      = (r_state == S_GRANT) &
                      (~req[r_sel] | (w_xfer & (r_bcnt == c_last)));
  // On release the old owner drops to lowest priority for the same-edge re-arbitration.
  assign w_scan_ptr = w_rel ? (r_sel + 2'd1) : r_ptr;
  assign w_win      = f_arb(req, w_scan_ptr);

  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_sel_n   = r_sel;
    w_ptr_n   = r_ptr;
    w_bcnt_n  = r_bcnt;
    case (r_state)
      S_IDLE: begin
        if (req != 4'b0000) begin
          w_gnt_n   = 4'b0001 << w_win;
          w_sel_n   = w_win;
          w_bcnt_n  = 4'd0;
          w_state_n = S_GRANT;
        end
      end
      default: begin
        if (w_rel) begin
          w_ptr_n  = r_sel + 2'd1;
          w_bcnt_n = 4'd0;
          if (req != 4'b0000) begin
            w_gnt_n   = 4'b0001 << w_win;
            w_sel_n   = w_win;
            w_state_n = S_GRANT;
          end else begin
            w_gnt_n   = 4'b0000;
            w_sel_n   = 2'd0;
            w_state_n = S_IDLE;
          end
        end else if (w_xfer) begin
          w_bcnt_n = r_bcnt + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
      r_bcnt  <= 4'd0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_sel   <= w_sel_n;
      r_ptr   <= w_ptr_n;
      r_bcnt  <= w_bcnt_n;
    end
  end

endmodule

`default_nettype wire
